// File: rtl/ascon_round_sequencer.sv
// Control FSM sequencing one ASCON AEAD run: init, associated data, text, finalization.
// Optional AD phase compiled in only when ASCON_SEQ_AD_EN is defined.
module ascon_round_sequencer #(
  parameter int unsigned PA_LAST = 11
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [3:0] counter_i,
  input  logic       block_valid_i,
  input  logic       block_last_i,
  output logic       block_ready_o,
  output logic       cnt_enable_o,
  output logic       cnt_init_a_o,
  output logic       cnt_init_b_o,
  output logic       round_en_o,
  output logic       absorb_o,
  output logic       key_xor_begin_o,
  output logic       key_xor_end_o,
  output logic       domain_sep_o,
  output logic       done_o,
  output logic [2:0] phase_o
);

  localparam logic [3:0] LAST_CNT = 4'(PA_LAST);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_CONF,
    S_INIT_PERM,
    S_INIT_END,
`ifdef ASCON_SEQ_AD_EN
    S_AD_WAIT,
    S_AD_CONF,
    S_AD_PERM,
`endif
    S_DOM_SEP,
    S_TEXT_WAIT,
    S_TEXT_CONF,
    S_TEXT_PERM,
    S_FIN_CONF,
    S_FIN_PERM,
    S_FIN_END
  } state_t;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_INIT  = 3'd1,
    PH_AD    = 3'd2,
    PH_TEXT  = 3'd3,
    PH_FINAL = 3'd4
  } phase_t;

  state_t state_q, state_d;
  phase_t phase;

  // NOTE: state register uses non-blocking assignment; the async reset is in the sensitivity list.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // NOTE: every output and state_d gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_d         = state_q;
    block_ready_o   = 1'b0;
    cnt_enable_o    = 1'b0;
    cnt_init_a_o    = 1'b0;
    cnt_init_b_o    = 1'b0;
    round_en_o      = 1'b0;
    key_xor_begin_o = 1'b0;
    key_xor_end_o   = 1'b0;
    domain_sep_o    = 1'b0;
    done_o          = 1'b0;
    phase           = PH_IDLE;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_INIT_CONF;
      end

      S_INIT_CONF: begin
        phase        = PH_INIT;
        cnt_enable_o = 1'b1;
        cnt_init_a_o = 1'b1;
        state_d      = S_INIT_PERM;
      end

      // p^a loads 14, so the first two cycles (14, 15) are idle rounds.
      S_INIT_PERM: begin
        phase        = PH_INIT;
        cnt_enable_o = 1'b1;
        round_en_o   = (counter_i <= LAST_CNT);
        if (counter_i == LAST_CNT) state_d = S_INIT_END;
      end

      S_INIT_END: begin
        phase         = PH_INIT;
        key_xor_end_o = 1'b1;
`ifdef ASCON_SEQ_AD_EN
        state_d       = S_AD_WAIT;
`else
        state_d       = S_DOM_SEP;
`endif
      end

`ifdef ASCON_SEQ_AD_EN
      S_AD_WAIT: begin
        phase         = PH_AD;
        block_ready_o = 1'b1;
        if (block_valid_i) state_d = block_last_i ? S_DOM_SEP : S_AD_CONF;
      end

      S_AD_CONF: begin
        phase        = PH_AD;
        cnt_enable_o = 1'b1;
        cnt_init_b_o = 1'b1;
        state_d      = S_AD_PERM;
      end

      S_AD_PERM: begin
        phase        = PH_AD;
        cnt_enable_o = 1'b1;
        round_en_o   = 1'b1;
        if (counter_i == LAST_CNT) state_d = S_AD_WAIT;
      end
`endif

      // Domain separation opens the text phase, so it reports the text phase code.
      S_DOM_SEP: begin
        phase        = PH_TEXT;
        domain_sep_o = 1'b1;
        state_d      = S_TEXT_WAIT;
      end

      S_TEXT_WAIT: begin
        phase         = PH_TEXT;
        block_ready_o = 1'b1;
        if (block_valid_i) state_d = block_last_i ? S_FIN_CONF : S_TEXT_CONF;
      end

      S_TEXT_CONF: begin
        phase        = PH_TEXT;
        cnt_enable_o = 1'b1;
        cnt_init_b_o = 1'b1;
        state_d      = S_TEXT_PERM;
      end

      S_TEXT_PERM: begin
        phase        = PH_TEXT;
        cnt_enable_o = 1'b1;
        round_en_o   = 1'b1;
        if (counter_i == LAST_CNT) state_d = S_TEXT_WAIT;
      end

      S_FIN_CONF: begin
        phase           = PH_FINAL;
        cnt_enable_o    = 1'b1;
        cnt_init_a_o    = 1'b1;
        key_xor_begin_o = 1'b1;
        state_d         = S_FIN_PERM;
      end

      S_FIN_PERM: begin
        phase        = PH_FINAL;
        cnt_enable_o = 1'b1;
        round_en_o   = (counter_i <= LAST_CNT);
        if (counter_i == LAST_CNT) state_d = S_FIN_END;
      end

      S_FIN_END: begin
        phase         = PH_FINAL;
        key_xor_end_o = 1'b1;
        done_o        = 1'b1;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign absorb_o = block_valid_i & block_ready_o;
  assign phase_o  = phase;

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Scoreboard bench for ascon_round_sequencer: a run-level model plans inputs and expected outputs per cycle,
// a driver plays them, and a negedge monitor compares the DUT against the queued expectations.
module tb_ascon_round_sequencer;

  typedef struct packed {
    logic       ready;
    logic       enable;
    logic       init_a;
    logic       init_b;
    logic       round_en;
    logic       absorb;
    logic       kxb;
    logic       kxe;
    logic       dsep;
    logic       done;
    logic [2:0] phase;
  } out_t;

  typedef struct packed {
    logic start;
    logic valid;
    logic last;
  } in_t;

  logic       clock_i;
  logic       resetb_i;
  logic       start_i;
  logic [3:0] counter_i;
  logic       block_valid_i;
  logic       block_last_i;
  logic       block_ready_o;
  logic       cnt_enable_o;
  logic       cnt_init_a_o;
  logic       cnt_init_b_o;
  logic       round_en_o;
  logic       absorb_o;
  logic       key_xor_begin_o;
  logic       key_xor_end_o;
  logic       domain_sep_o;
  logic       done_o;
  logic [2:0] phase_o;

  ascon_round_sequencer #(.PA_LAST(11)) dut (
    .clock_i         (clock_i),
    .resetb_i        (resetb_i),
    .start_i         (start_i),
    .counter_i       (counter_i),
    .block_valid_i   (block_valid_i),
    .block_last_i    (block_last_i),
    .block_ready_o   (block_ready_o),
    .cnt_enable_o    (cnt_enable_o),
    .cnt_init_a_o    (cnt_init_a_o),
    .cnt_init_b_o    (cnt_init_b_o),
    .round_en_o      (round_en_o),
    .absorb_o        (absorb_o),
    .key_xor_begin_o (key_xor_begin_o),
    .key_xor_end_o   (key_xor_end_o),
    .domain_sep_o    (domain_sep_o),
    .done_o          (done_o),
    .phase_o         (phase_o)
  );

  out_t dut_out;
  assign dut_out = {block_ready_o, cnt_enable_o, cnt_init_a_o, cnt_init_b_o, round_en_o, absorb_o,
                    key_xor_begin_o, key_xor_end_o, domain_sep_o, done_o, phase_o};

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // Round counter environment: loads 14 / 4 and counts while enabled.
  always @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i)         counter_i <= 4'd0;
    else if (cnt_init_a_o) counter_i <= 4'd14;
    else if (cnt_init_b_o) counter_i <= 4'd4;
    else if (cnt_enable_o) counter_i <= counter_i + 4'd1;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  out_t exp_q[$];
  int   idx_q[$];

  always @(negedge clock_i) begin
    if (done_o) done_seen++;
    if (exp_q.size() > 0) begin
      out_t e;
      int   k;
      e = exp_q.pop_front();
      k = idx_q.pop_front();
      check($sformatf("cycle_%0d_outputs(rdy,en,ia,ib,rnd,abs,kxb,kxe,ds,done,ph)", k), 32'(dut_out), 32'(e));
    end
  end

  // ---------------- reference model ----------------
  in_t  plan_in[$];
  out_t plan_exp[$];
  int   t_run;
  bit   blk_pend;
  int   blk_rise;
  bit   blk_last;
  bit   blk_list[$];
  bit   acc_now;
  bit   acc_last;
  int   rst_at;

  function automatic out_t mk(input int ph);
    out_t o;
    o = '0;
    o.phase = 3'(ph);
    return o;
  endfunction

  // start_mode: 0 low, 1 high, 2 random (used only where the FSM is busy).
  task automatic emit(input out_t o, input int start_mode);
    in_t i;
    i.start = (start_mode == 1) ? 1'b1 : (start_mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
    i.valid = blk_pend && (t_run >= blk_rise);
    i.last  = i.valid ? blk_last : 1'($urandom_range(0, 1));
    o.absorb = i.valid & o.ready;
    acc_now  = o.absorb;
    if (o.absorb) begin
      acc_last = blk_last;
      blk_pend = 1'b0;
      if (blk_list.size() > 0) begin
        blk_last = blk_list.pop_front();
        blk_pend = 1'b1;
        blk_rise = t_run + 1 + int'($urandom_range(0, 12));
      end
    end
    plan_in.push_back(i);
    plan_exp.push_back(o);
    t_run++;
  endtask

  // p^a: CONF + 14 rounds (first two idle); p^b: CONF + 8 active rounds.
  task automatic perm(input bit is_a, input int ph, input bit kxb);
    out_t o;
    o = mk(ph);
    o.enable = 1'b1;
    o.init_a = is_a;
    o.init_b = !is_a;
    o.kxb    = kxb;
    emit(o, 2);
    for (int i = 0; i < (is_a ? 14 : 8); i++) begin
      o = mk(ph);
      o.enable   = 1'b1;
      o.round_en = is_a ? (i >= 2) : 1'b1;
      if (!is_a && i == 3 && rst_at < 0) rst_at = t_run;
      emit(o, 2);
    end
  endtask

  task automatic wait_block(input int ph);
    out_t o;
    do begin
      o = mk(ph);
      o.ready = 1'b1;
      emit(o, 2);
    end while (!acc_now);
  endtask

  task automatic build_run(input int n_ad, input int n_tx);
    out_t o;
    t_run = 0;
    rst_at = -1;
    blk_list.delete();
`ifdef ASCON_SEQ_AD_EN
    for (int i = 0; i < n_ad; i++) blk_list.push_back(i == n_ad - 1);
`endif
    for (int i = 0; i < n_tx; i++) blk_list.push_back(i == n_tx - 1);
    blk_last = blk_list.pop_front();
    blk_pend = 1'b1;
    blk_rise = int'($urandom_range(1, 20));

    emit(mk(0), 1);
    perm(1'b1, 1, 1'b0);
    o = mk(1); o.kxe = 1'b1; emit(o, 2);
`ifdef ASCON_SEQ_AD_EN
    do begin
      wait_block(2);
      if (!acc_last) perm(1'b0, 2, 1'b0);
    end while (!acc_last);
`endif
    o = mk(3); o.dsep = 1'b1; emit(o, 2);
    do begin
      wait_block(3);
      if (!acc_last) perm(1'b0, 3, 1'b0);
    end while (!acc_last);
    perm(1'b1, 4, 1'b1);
    o = mk(4); o.kxe = 1'b1; o.done = 1'b1; emit(o, 2);
    repeat ($urandom_range(1, 3)) emit(mk(0), 0);
  endtask

  // ---------------- driver ----------------
  task automatic play(input int upto);
    for (int k = 0; k < upto; k++) begin
      @(posedge clock_i);
      #1;
      start_i       = plan_in[k].start;
      block_valid_i = plan_in[k].valid;
      block_last_i  = plan_in[k].last;
      exp_q.push_back(plan_exp[k]);
      idx_q.push_back(k);
    end
  endtask

  task automatic play_all();
    play(plan_in.size());
    @(negedge clock_i);
    #1;
    plan_in.delete();
    plan_exp.delete();
  endtask

  initial begin
    int done_before;
    resetb_i      = 1'b0;
    start_i       = 1'b0;
    block_valid_i = 1'b0;
    block_last_i  = 1'b0;
    blk_pend      = 1'b0;
    t_run         = 0;

    repeat (3) @(posedge clock_i);
    #1;
    check("reset_outputs", 32'(dut_out), 32'd0);
    check("reset_phase", 32'(phase_o), 32'd0);
    @(negedge clock_i);
    resetb_i = 1'b1;

    repeat (20) emit(mk(0), 0);
    play_all();

    build_run(2, 3);
    play_all();

    for (int r = 0; r < 10; r++) begin
      build_run($urandom_range(1, 3), $urandom_range(1, 3));
      play_all();
    end

    // Reset in the middle of a p^b permutation (counter = 7).
    build_run(2, 2);
    play(rst_at);
    @(posedge clock_i);
    #1;
    start_i       = plan_in[rst_at].start;
    block_valid_i = plan_in[rst_at].valid;
    block_last_i  = plan_in[rst_at].last;
    #1;
    check("counter_before_reset", 32'(counter_i), 32'd7);
    done_before = done_seen;
    resetb_i = 1'b0;
    #1;
    check("reset_mid_run_outputs", 32'(dut_out), 32'd0);
    start_i       = 1'b0;
    block_valid_i = 1'b0;
    block_last_i  = 1'b0;
    plan_in.delete();
    plan_exp.delete();
    repeat (3) @(posedge clock_i);
    #1;
    check("reset_hold_outputs", 32'(dut_out), 32'd0);
    @(negedge clock_i);
    resetb_i = 1'b1;
    repeat (4) @(posedge clock_i);
    #1;
    check("no_done_after_reset", 32'(done_seen - done_before), 32'd0);

    build_run(1, 1);
    play_all();
    check("done_after_fresh_run", 32'(done_seen - done_before), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
